// File: rtl/evm_pkg.sv
// Shared constants for the EVM result stage.
// Default sizing, FSM state encoding and index-width helper.
package evm_pkg;

    localparam int NUM_CAND_DEF = 4;
    localparam int CW_DEF       = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SNAP   = 2'd1;
    localparam state_t S_SCAN   = 2'd2;
    localparam state_t S_REPORT = 2'd3;

    function automatic int idw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evm_max_tracker.sv
// Running max / index / tie / sum accumulator for the result scan.
// The *_nx outputs already include the candidate presented this cycle.
module evm_max_tracker #(
    parameter int CW  = 4,
    parameter int IDW = 2,
    localparam int SW = CW + IDW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    input  logic [CW-1:0]  val,
    input  logic [IDW-1:0] k,
    output logic [CW-1:0]  max_nx,
    output logic [IDW-1:0] idx_nx,
    output logic           tie_nx,
    output logic [SW-1:0]  sum_nx
);

    logic [CW-1:0]  max_q, max_d;
    logic [IDW-1:0] idx_q, idx_d;
    logic           tie_q, tie_d;
    logic [SW-1:0]  sum_q, sum_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
            tie_q <= 1'b0;
            sum_q <= '0;
        end else begin
            max_q <= max_d;
            idx_q <= idx_d;
            tie_q <= tie_d;
            sum_q <= sum_d;
        end
    end

    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        tie_d = tie_q;
        sum_d = sum_q;
        if (clear) begin
            max_d = '0;
            idx_d = '0;
            tie_d = 1'b0;
            sum_d = '0;
        end else if (step) begin
            sum_d = sum_q + SW'(val);
            // strict > keeps the lowest index on equal counts
            if (val > max_q) begin
                max_d = val;
                idx_d = k;
                tie_d = 1'b0;
            end else if (val == max_q && max_q != '0) begin
                tie_d = 1'b1;
            end
        end
    end

    assign max_nx = max_d;
    assign idx_nx = idx_d;
    assign tie_nx = tie_d;
    assign sum_nx = sum_d;

endmodule

// File: rtl/evm_result_unit.sv
// EVM post-poll result stage: snapshot, scan for winner, stream report.
// FSM IDLE -> SNAP -> SCAN -> REPORT -> IDLE; one counter serves scan and report.
module evm_result_unit
    import evm_pkg::*;
#(
    parameter int NUM_CAND = NUM_CAND_DEF,
    parameter int CW       = CW_DEF,
    localparam int IDW     = idw_of(NUM_CAND),
    localparam int SW      = CW + IDW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   close_poll,
    input  logic [NUM_CAND*CW-1:0] counts_in,
    output logic                   busy,
    output logic                   done,
    output logic [IDW-1:0]         winner_id,
    output logic [CW-1:0]          winner_count,
    output logic                   tie,
    output logic                   no_votes,
    output logic [SW-1:0]          total_votes,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [IDW-1:0]         rpt_id,
    output logic [CW-1:0]          rpt_count
);

    localparam logic [IDW-1:0] LAST = IDW'(NUM_CAND - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]  snap_q [NUM_CAND];
    logic [CW-1:0]  snap_d [NUM_CAND];
    logic [IDW-1:0] win_id_q, win_id_d;
    logic [CW-1:0]  win_cnt_q, win_cnt_d;
    logic           tie_q, tie_d;
    logic           nv_q, nv_d;
    logic [SW-1:0]  tot_q, tot_d;
    logic           done_q, done_d;

    logic [CW-1:0]  max_nx;
    logic [IDW-1:0] idx_nx;
    logic           tie_nx;
    logic [SW-1:0]  sum_nx;
    logic           last;
    logic           fire;

    assign last = (cnt_q == LAST);
    assign fire = rpt_valid && rpt_ready;

    evm_max_tracker #(
        .CW  (CW),
        .IDW (IDW)
    ) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == S_SNAP),
        .step   (state_q == S_SCAN),
        .val    (snap_q[cnt_q]),
        .k      (cnt_q),
        .max_nx (max_nx),
        .idx_nx (idx_nx),
        .tie_nx (tie_nx),
        .sum_nx (sum_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_id_q  <= '0;
            win_cnt_q <= '0;
            tie_q     <= 1'b0;
            nv_q      <= 1'b0;
            tot_q     <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_id_q  <= win_id_d;
            win_cnt_q <= win_cnt_d;
            tie_q     <= tie_d;
            nv_q      <= nv_d;
            tot_q     <= tot_d;
            done_q    <= done_d;
            for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= snap_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        win_id_d  = win_id_q;
        win_cnt_d = win_cnt_q;
        tie_d     = tie_q;
        nv_d      = nv_q;
        tot_d     = tot_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (close_poll) state_d = S_SNAP;
            end
            S_SNAP: begin
                state_d   = S_SCAN;
                cnt_d     = '0;
                win_id_d  = '0;
                win_cnt_d = '0;
                tie_d     = 1'b0;
                nv_d      = 1'b0;
                tot_d     = '0;
                for (int i = 0; i < NUM_CAND; i++) snap_d[i] = counts_in[i*CW +: CW];
            end
            S_SCAN: begin
                if (last) begin
                    state_d   = S_REPORT;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    nv_d      = (sum_nx == '0);
                    win_id_d  = nv_d ? '0 : idx_nx;
                    win_cnt_d = nv_d ? '0 : max_nx;
                    tie_d     = tie_nx;
                    tot_d     = sum_nx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (fire) begin
                    if (last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        rpt_valid = (state_q == S_REPORT);
        rpt_id    = rpt_valid ? cnt_q : '0;
        rpt_count = rpt_valid ? snap_q[cnt_q] : '0;
    end

    assign done         = done_q;
    assign winner_id    = win_id_q;
    assign winner_count = win_cnt_q;
    assign tie          = tie_q;
    assign no_votes     = nv_q;
    assign total_votes  = tot_q;

endmodule

// File: tb/tb_evm_result_unit.sv
// Bench for evm_result_unit: directed polls plus randomized polls
// checked against a plain arithmetic reference of the result rules.
module tb_evm_result_unit;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              close_poll = 1'b0;
    logic [N*CW-1:0]   counts_in = '0;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    winner_id;
    logic [CW-1:0]     winner_count;
    logic              tie;
    logic              no_votes;
    logic [CW+IDW-1:0] total_votes;
    logic              rpt_valid;
    logic              rpt_ready = 1'b0;
    logic [IDW-1:0]    rpt_id;
    logic [CW-1:0]     rpt_count;

    int checks = 0;
    int errors = 0;
    int cur [N];
    int exp_win, exp_wc, exp_tie, exp_nv, exp_tot;

    evm_result_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .close_poll   (close_poll),
        .counts_in    (counts_in),
        .busy         (busy),
        .done         (done),
        .winner_id    (winner_id),
        .winner_count (winner_count),
        .tie          (tie),
        .no_votes     (no_votes),
        .total_votes  (total_votes),
        .rpt_valid    (rpt_valid),
        .rpt_ready    (rpt_ready),
        .rpt_id       (rpt_id),
        .rpt_count    (rpt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        int mx, nmx;
        mx = 0;
        exp_tot = 0;
        for (int i = 0; i < N; i++) begin
            exp_tot += cur[i];
            if (cur[i] > mx) mx = cur[i];
        end
        nmx = 0;
        exp_win = -1;
        for (int i = 0; i < N; i++) begin
            if (cur[i] == mx) begin
                nmx++;
                if (exp_win < 0) exp_win = i;
            end
        end
        exp_nv  = (exp_tot == 0) ? 1 : 0;
        exp_tie = (mx != 0 && nmx > 1) ? 1 : 0;
        if (exp_nv == 1) exp_win = 0;
        exp_wc  = mx;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wid"}, winner_id, 0);
        chk({tag, "_wcnt"}, winner_count, 0);
        chk({tag, "_tie"}, tie, 0);
        chk({tag, "_nv"}, no_votes, 0);
        chk({tag, "_tot"}, total_votes, 0);
        chk({tag, "_rvalid"}, rpt_valid, 0);
        chk({tag, "_rid"}, rpt_id, 0);
        chk({tag, "_rcnt"}, rpt_count, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall on beat 1
    task automatic run_poll(input string tag, input int mode, input bit disturb);
        int n, beat, stall, dones, cyc;
        bit held, r;
        logic [IDW-1:0] hid;
        logic [CW-1:0] hcnt;
        for (int i = 0; i < N; i++) counts_in[i*CW +: CW] = cur[i][CW-1:0];
        model();
        close_poll = 1'b1;
        @(posedge clk);
        #1 close_poll = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            if (disturb && n == 2) begin
                counts_in  = N*CW'($urandom);
                close_poll = 1'b1;
            end else begin
                close_poll = 1'b0;
            end
        end while (!done && n < 20);
        close_poll = 1'b0;
        chk({tag, "_done_lat"}, n, N + 1);
        chk({tag, "_wid"}, winner_id, exp_win);
        chk({tag, "_wcnt"}, winner_count, exp_wc);
        chk({tag, "_tie"}, tie, exp_tie);
        chk({tag, "_nv"}, no_votes, exp_nv);
        chk({tag, "_tot"}, total_votes, exp_tot);
        beat = 0; stall = 0; dones = 0; cyc = 0; held = 0;
        hid = '0; hcnt = '0;
        while (beat < N && cyc < 60) begin
            chk({tag, "_rvalid"}, rpt_valid, 1);
            if (held) begin
                chk({tag, "_hold_id"}, rpt_id, hid);
                chk({tag, "_hold_cnt"}, rpt_count, hcnt);
            end
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'($urandom % 2);
            else r = !(beat == 1 && stall < 3);
            if (mode == 2 && !r) stall++;
            rpt_ready = r;
            if (rpt_valid && r) begin
                chk({tag, "_beat_id"}, rpt_id, beat);
                chk({tag, "_beat_cnt"}, rpt_count, cur[beat]);
                beat++;
                held = 1'b0;
            end else begin
                held = rpt_valid;
                hid  = rpt_id;
                hcnt = rpt_count;
            end
            if (beat < N && mode == 2 && beat >= 2) chk({tag, "_busy_mid"}, busy, 1);
            @(posedge clk);
            #1 cyc++;
            if (done) dones++;
        end
        rpt_ready = 1'b0;
        chk({tag, "_beats"}, beat, N);
        if (mode == 0) chk({tag, "_report_cycles"}, cyc, N);
        if (mode == 2) chk({tag, "_stalls"}, stall, 3);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_rvalid_end"}, rpt_valid, 0);
        chk({tag, "_extra_done"}, dones, 0);
        chk({tag, "_wid_hold"}, winner_id, exp_win);
        chk({tag, "_tot_hold"}, total_votes, exp_tot);
        if (disturb) begin
            dones = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1 if (done || busy) dones++;
            end
            chk({tag, "_no_second_run"}, dones, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cur = '{2, 1, 0, 1};
        run_poll("t1_basic", 0, 1'b0);

        cur = '{3, 0, 1, 3};
        run_poll("t2_tie", 0, 1'b0);

        cur = '{0, 0, 0, 0};
        run_poll("t3_zero", 0, 1'b0);

        cur = '{5, 9, 9, 2};
        run_poll("t4_backpressure", 2, 1'b0);

        cur = '{1, 7, 4, 6};
        run_poll("t5_disturb", 0, 1'b1);

        cur = '{4, 4, 8, 1};
        for (int i = 0; i < N; i++) counts_in[i*CW +: CW] = cur[i][CW-1:0];
        close_poll = 1'b1;
        @(posedge clk);
        #1 close_poll = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("t6_in_reset");
        @(posedge clk);
        #1 chk_zero("t6_hold_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_zero("t6_after_reset");
        cur = '{15, 15, 15, 15};
        run_poll("t6_all15", 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++)
                cur[i] = (t % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            run_poll("rand", 1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
